// File: rtl/spi_counter_slave_rx.sv
// SPI mode-0 slave receiver for the master->slave counter link.
// Latches a 14-bit counter per well-formed 16-bit frame and shifts the previous value back on miso.
module spi_counter_slave_rx #(
  parameter int FRAME_BITS = 16,
  parameter int CNT_BITS   = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sclk,
  input  logic                mosi,
  input  logic                ss,
  output logic                miso,
  output logic [CNT_BITS-1:0] o_counter,
  output logic                o_data_valid,
  output logic                o_frame_err,
  output logic                o_busy
);

  localparam int            CW   = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0] FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] SAT  = CW'(FRAME_BITS + 1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t                r_state;
  logic [2:0]            r_sclk_pipe;
  logic [2:0]            r_ss_pipe;
  logic [1:0]            r_mosi_pipe;
  logic [1:0]            r_arm_cnt;
  logic [CW-1:0]         r_bit_cnt;
  logic [CNT_BITS-1:0]   r_rx_shift;
  logic [FRAME_BITS-1:0] r_tx_shift;
  logic                  r_done_ok;
  logic                  r_done_err;

  logic w_armed;
  logic w_ss_fall;
  logic w_ss_rise;
  logic w_sclk_rise;
  logic w_sclk_fall;

  // The pipes reset to idle levels, so edges are ignored until they have refilled
  // with real pin values; a pin already low at reset release is never seen as a fresh edge.
  assign w_armed     = (r_arm_cnt == 2'd3);
  assign w_ss_fall   = w_armed &&  r_ss_pipe[2]   && !r_ss_pipe[1];
  assign w_ss_rise   = w_armed && !r_ss_pipe[2]   &&  r_ss_pipe[1];
  assign w_sclk_rise = w_armed && !r_sclk_pipe[2] &&  r_sclk_pipe[1];
  assign w_sclk_fall = w_armed &&  r_sclk_pipe[2] && !r_sclk_pipe[1];

  assign o_busy = (r_state == S_ACTIVE);

  // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_sclk_pipe  <= 3'b000;
      r_ss_pipe    <= 3'b111;
      r_mosi_pipe  <= 2'b00;
      r_arm_cnt    <= 2'd0;
      r_bit_cnt    <= '0;
      r_rx_shift   <= '0;
      r_tx_shift   <= '0;
      r_done_ok    <= 1'b0;
      r_done_err   <= 1'b0;
      miso         <= 1'b0;
      o_counter    <= '0;
      o_data_valid <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      r_sclk_pipe <= {r_sclk_pipe[1:0], sclk};
      r_ss_pipe   <= {r_ss_pipe[1:0], ss};
      r_mosi_pipe <= {r_mosi_pipe[0], mosi};
      if (!w_armed) r_arm_cnt <= r_arm_cnt + 2'd1;

      r_done_ok    <= 1'b0;
      r_done_err   <= 1'b0;
      o_data_valid <= r_done_ok;
      o_frame_err  <= r_done_err;
      if (r_done_ok) o_counter <= r_rx_shift;
      miso <= (r_state == S_ACTIVE) ? r_tx_shift[FRAME_BITS-1] : 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_ss_fall) begin
            r_state    <= S_ACTIVE;
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_tx_shift <= {{(FRAME_BITS-CNT_BITS){1'b0}}, o_counter};
          end
        end
        S_ACTIVE: begin
          if (w_ss_rise) begin
            r_state <= S_IDLE;
            if (r_bit_cnt == FULL) r_done_ok  <= 1'b1;
            else                   r_done_err <= 1'b1;
          end else if (w_sclk_rise) begin
            r_rx_shift <= {r_rx_shift[CNT_BITS-2:0], r_mosi_pipe[1]};
            if (r_bit_cnt != SAT) r_bit_cnt <= r_bit_cnt + 1'b1;
          end else if (w_sclk_fall) begin
            r_tx_shift <= {r_tx_shift[FRAME_BITS-2:0], 1'b0};
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_counter_slave_rx.sv
// Bench for spi_counter_slave_rx: acts as an SPI mode-0 master and compares against
// a frame-level model (last good counter, readback of the previous value).
module tb_spi_counter_slave_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        sclk;
  logic        mosi;
  logic        ss;
  logic        miso;
  logic [13:0] o_counter;
  logic        o_data_valid;
  logic        o_frame_err;
  logic        o_busy;

  int checks   = 0;
  int failures = 0;

  int n_valid = 0;
  int n_err   = 0;
  int n_both  = 0;
  int n_long  = 0;
  logic prev_v = 1'b0;
  logic prev_e = 1'b0;

  logic [13:0] m_counter;

  spi_counter_slave_rx dut (
    .clk          (clk),
    .reset        (reset),
    .sclk         (sclk),
    .mosi         (mosi),
    .ss           (ss),
    .miso         (miso),
    .o_counter    (o_counter),
    .o_data_valid (o_data_valid),
    .o_frame_err  (o_frame_err),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (o_data_valid) n_valid++;
    if (o_frame_err) n_err++;
    if (o_data_valid && o_frame_err) n_both++;
    if ((o_data_valid && prev_v) || (o_frame_err && prev_e)) n_long++;
    prev_v = o_data_valid;
    prev_e = o_frame_err;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected miso sequence: previous counter zero-padded to 16 bits, MSB first, then zeros.
  function automatic logic [31:0] exp_miso(input logic [13:0] prev, input int n);
    logic [31:0] rb;
    rb = {18'd0, prev};
    if (n <= 16) return rb >> (16 - n);
    return rb << (n - 16);
  endfunction

  task automatic send_bits(input logic [31:0] data, input int n, input int h,
                           output logic [31:0] cap);
    cap = '0;
    ss  = 1'b0;
    for (int i = 0; i < n; i++) begin
      mosi = data[n-1-i];
      wait_clk(h);
      cap  = {cap[30:0], miso};
      sclk = 1'b1;
      wait_clk(h);
      sclk = 1'b0;
    end
    mosi = 1'b0;
    wait_clk(h);
  endtask

  task automatic end_frame(output logic v, output logic e, output logic b2, output logic b3,
                           output logic shape_ok, output logic [13:0] cnt);
    logic pre_v, pre_e;
    ss = 1'b1;
    wait_clk(2);
    b2 = o_busy;
    wait_clk(1);
    b3    = o_busy;
    pre_v = o_data_valid;
    pre_e = o_frame_err;
    wait_clk(1);
    v   = o_data_valid;
    e   = o_frame_err;
    cnt = o_counter;
    wait_clk(1);
    shape_ok = !pre_v && !pre_e && !o_data_valid && !o_frame_err;
    wait_clk(6);
  endtask

  task automatic run_frame(input logic [31:0] data, input int n, input int h,
                           output logic [31:0] cap, output logic v, output logic e,
                           output logic shape_ok, output logic [13:0] cnt);
    logic b2, b3;
    send_bits(data, n, h, cap);
    end_frame(v, e, b2, b3, shape_ok, cnt);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    ss    = 1'b0;
    sclk  = 1'b0;
    mosi  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_clk(1);
      sclk = ~sclk;
    end
    sclk = 1'b0;
    checks++; if (miso !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b exp=0", miso); end
    checks++; if (o_counter !== 14'h0) begin failures++; $display("FAIL reset_counter got=%h exp=0000", o_counter); end
    checks++; if (o_data_valid !== 1'b0 || o_frame_err !== 1'b0) begin
      failures++; $display("FAIL reset_pulses got v=%b e=%b exp 0 0", o_data_valid, o_frame_err);
    end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sclk = ~sclk;
      wait_clk(4);
    end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_stale_ss_busy got=%b exp=0", o_busy); end
    ss = 1'b1;
    wait_clk(10);
    checks++; if (n_valid !== 0 || n_err !== 0) begin
      failures++; $display("FAIL reset_no_pulse got valid=%0d err=%0d exp 0 0", n_valid, n_err);
    end
    checks++; if (o_counter !== 14'h0) begin failures++; $display("FAIL reset_counter_after got=%h exp=0000", o_counter); end
    m_counter = 14'h0;
  endtask

  task automatic test_single_frame;
    logic [31:0] cap;
    logic v, e, b2, b3, shape_ok;
    logic [13:0] cnt;
    int err0;
    err0 = n_err;
    send_bits(32'h0ABC, 16, 5, cap);
    checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL single_busy_active got=%b exp=1", o_busy); end
    end_frame(v, e, b2, b3, shape_ok, cnt);
    checks++; if (v !== 1'b1) begin failures++; $display("FAIL single_valid_at_4 got=%b exp=1", v); end
    checks++; if (cnt !== 14'h0ABC) begin failures++; $display("FAIL single_counter got=%h exp=0abc", cnt); end
    checks++; if (shape_ok !== 1'b1) begin failures++; $display("FAIL single_pulse_shape got=%b exp=1", shape_ok); end
    checks++; if (b2 !== 1'b1 || b3 !== 1'b0) begin
      failures++; $display("FAIL single_busy_fall got=%b%b exp=10", b2, b3);
    end
    checks++; if (cap !== exp_miso(m_counter, 16)) begin
      failures++; $display("FAIL single_readback got=%h exp=%h", cap, exp_miso(m_counter, 16));
    end
    checks++; if (n_err !== err0) begin failures++; $display("FAIL single_no_err got=%0d exp=%0d", n_err, err0); end
    m_counter = 14'h0ABC;
  endtask

  task automatic test_bad_length;
    logic [31:0] cap;
    logic v, e, shape_ok;
    logic [13:0] cnt;
    run_frame(32'h1555, 15, 5, cap, v, e, shape_ok, cnt);
    checks++; if (e !== 1'b1 || v !== 1'b0) begin
      failures++; $display("FAIL short_err got v=%b e=%b exp 0 1", v, e);
    end
    checks++; if (cnt !== 14'h0ABC || o_counter !== 14'h0ABC) begin
      failures++; $display("FAIL short_keep_counter got=%h/%h exp=0abc", cnt, o_counter);
    end
    checks++; if (cap !== exp_miso(m_counter, 15)) begin
      failures++; $display("FAIL short_readback got=%h exp=%h", cap, exp_miso(m_counter, 15));
    end
    run_frame(32'h1FFFF, 17, 5, cap, v, e, shape_ok, cnt);
    checks++; if (e !== 1'b1 || v !== 1'b0) begin
      failures++; $display("FAIL long_err got v=%b e=%b exp 0 1", v, e);
    end
    checks++; if (cnt !== 14'h0ABC) begin failures++; $display("FAIL long_keep_counter got=%h exp=0abc", cnt); end
    checks++; if (shape_ok !== 1'b1) begin failures++; $display("FAIL long_pulse_shape got=%b exp=1", shape_ok); end
  endtask

  task automatic test_readback;
    logic [31:0] cap;
    logic v, e, shape_ok;
    logic [13:0] cnt;
    run_frame(32'h1234, 16, 5, cap, v, e, shape_ok, cnt);
    checks++; if (v !== 1'b1 || cnt !== 14'h1234) begin
      failures++; $display("FAIL readback_first got v=%b cnt=%h exp 1 1234", v, cnt);
    end
    m_counter = 14'h1234;
    run_frame(32'h0001, 16, 5, cap, v, e, shape_ok, cnt);
    checks++; if (cap !== 32'h1234) begin failures++; $display("FAIL readback_miso got=%h exp=00001234", cap); end
    checks++; if (v !== 1'b1 || cnt !== 14'h0001) begin
      failures++; $display("FAIL readback_second got v=%b cnt=%h exp 1 0001", v, cnt);
    end
    m_counter = 14'h0001;
  endtask

  task automatic test_masking;
    logic [31:0] cap;
    logic v, e, shape_ok;
    logic [13:0] cnt;
    run_frame(32'hFFFF, 16, 5, cap, v, e, shape_ok, cnt);
    checks++; if (v !== 1'b1 || e !== 1'b0) begin
      failures++; $display("FAIL mask_valid got v=%b e=%b exp 1 0", v, e);
    end
    checks++; if (cnt !== 14'h3FFF) begin failures++; $display("FAIL mask_counter got=%h exp=3fff", cnt); end
    checks++; if (cap !== exp_miso(m_counter, 16)) begin
      failures++; $display("FAIL mask_readback got=%h exp=%h", cap, exp_miso(m_counter, 16));
    end
    m_counter = 14'h3FFF;
  endtask

  task automatic test_mid_reset;
    logic [31:0] cap;
    logic v, e, shape_ok;
    logic [13:0] cnt;
    int v0, e0;
    send_bits(32'h2A, 8, 5, cap);
    v0 = n_valid;
    e0 = n_err;
    reset = 1'b1;
    wait_clk(1);
    checks++; if (o_counter !== 14'h0 || o_busy !== 1'b0) begin
      failures++; $display("FAIL midreset_clear got cnt=%h busy=%b exp 0000 0", o_counter, o_busy);
    end
    wait_clk(2);
    reset = 1'b0;
    wait_clk(5);
    ss = 1'b1;
    wait_clk(12);
    checks++; if (n_valid !== v0 || n_err !== e0) begin
      failures++; $display("FAIL midreset_no_pulse got dv=%0d de=%0d exp 0 0", n_valid - v0, n_err - e0);
    end
    m_counter = 14'h0;
    run_frame(32'h0123, 16, 5, cap, v, e, shape_ok, cnt);
    checks++; if (v !== 1'b1 || cnt !== 14'h0123) begin
      failures++; $display("FAIL midreset_next_frame got v=%b cnt=%h exp 1 0123", v, cnt);
    end
    checks++; if (cap !== 32'h0) begin failures++; $display("FAIL midreset_readback got=%h exp=0", cap); end
    m_counter = 14'h0123;
  endtask

  task automatic test_random;
    logic [31:0] cap, data, exp_cap;
    logic v, e, shape_ok;
    logic [13:0] cnt;
    int n, h, r;
    for (int k = 0; k < 25; k++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 5)      n = 16;
      else if (r == 6) n = 15;
      else if (r == 7) n = 17;
      else if (r == 8) n = int'($urandom_range(0, 14));
      else             n = 18;
      h       = int'($urandom_range(4, 7));
      data    = $urandom & 32'((64'd1 << n) - 1);
      exp_cap = exp_miso(m_counter, n);
      run_frame(data, n, h, cap, v, e, shape_ok, cnt);
      if (n == 16) m_counter = data[13:0];
      checks++; if (v !== (n == 16) || e !== (n != 16)) begin
        failures++; $display("FAIL rand_pulse[%0d] n=%0d got v=%b e=%b", k, n, v, e);
      end
      checks++; if (cnt !== m_counter) begin
        failures++; $display("FAIL rand_counter[%0d] n=%0d got=%h exp=%h", k, n, cnt, m_counter);
      end
      checks++; if (cap !== exp_cap) begin
        failures++; $display("FAIL rand_readback[%0d] n=%0d got=%h exp=%h", k, n, cap, exp_cap);
      end
      checks++; if (shape_ok !== 1'b1) begin
        failures++; $display("FAIL rand_shape[%0d] got=%b exp=1", k, shape_ok);
      end
    end
  endtask

  task automatic test_pulse_rules;
    checks++; if (n_both !== 0) begin failures++; $display("FAIL pulses_exclusive got=%0d exp=0", n_both); end
    checks++; if (n_long !== 0) begin failures++; $display("FAIL pulses_one_clk got=%0d exp=0", n_long); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_bad_length();
    test_readback();
    test_masking();
    test_mid_reset();
    test_random();
    test_pulse_rules();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
